cam_ctrl: RTL and testbench

Command sequencer driving the `ram_img` pixel CAM from a valid/ready command stream. It turns write commands into CAM store cycles with an auto-incremented 14-bit index, and query commands into timed `match_en` lookups. Each command returns exactly one result on a valid/ready response channel. It sits between the image-streaming front end and `ram_img`, and is the only agent allowed to drive the CAM's `we`/`match_en`/`addr`/`din`.

---
 rtl/cam_ctrl_if.sv | 36 +++
 rtl/cam_ctrl.sv | 201 ++++++++++++++++++++
 tb/tb_cam_ctrl.sv | 368 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cam_ctrl_if.sv
// Command/response stream and ram_img CAM port bundle for cam_ctrl.
// slave = cam_ctrl side, master = front end / CAM environment side.
interface cam_ctrl_if #(
    parameter int unsigned KEY_W = 24,
    parameter int unsigned IDX_W = 14
);
    logic             s_valid;
    logic             s_ready;
    logic             s_mode;
    logic [KEY_W-1:0] s_key;

    logic             r_valid;
    logic             r_ready;
    logic             r_match;
    logic [IDX_W-1:0] r_idx;
    logic             r_err;
    logic             full;

    logic             cam_we;
    logic             cam_match_en;
    logic [KEY_W-1:0] cam_addr;
    logic [IDX_W-1:0] cam_din;
    logic             cam_match;

    modport slave (
        input  s_valid, s_mode, s_key, r_ready, cam_match,
        output s_ready, r_valid, r_match, r_idx, r_err, full,
        output cam_we, cam_match_en, cam_addr, cam_din
    );

    modport master (
        output s_valid, s_mode, s_key, r_ready, cam_match,
        input  s_ready, r_valid, r_match, r_idx, r_err, full,
        input  cam_we, cam_match_en, cam_addr, cam_din
    );
endinterface

// File: rtl/cam_ctrl.sv
// cam_ctrl: sequences writes (auto-indexed CAM stores) and timed queries against ram_img.
// Define CAM_CTRL_DUP_CHECK_EN to look up each write key first and refuse duplicates.
module cam_ctrl #(
    parameter int unsigned KEY_W     = 24,
    parameter int unsigned IDX_W     = 14,
    parameter int unsigned MATCH_LAT = 1
) (
    input  logic      clk,
    input  logic      rst,
    cam_ctrl_if.slave bus
);
    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_WRITE = 3'd1;
    localparam logic [2:0] ST_QUERY = 3'd2;
    localparam logic [2:0] ST_RESP  = 3'd3;
`ifdef CAM_CTRL_DUP_CHECK_EN
    localparam logic [2:0] ST_DCHK  = 3'd4;
`endif

    localparam logic [IDX_W-1:0] CNT_MAX  = '1;
    localparam logic [1:0]       LAT_LAST = 2'(MATCH_LAT - 1);

    logic [2:0]       state_q, state_d;
    logic [IDX_W-1:0] cnt_q, cnt_d;
    logic [1:0]       lat_q, lat_d;
    logic             s_ready_q, s_ready_d;
    logic             r_valid_q, r_valid_d;
    logic             r_match_q, r_match_d;
    logic [IDX_W-1:0] r_idx_q, r_idx_d;
    logic             r_err_q, r_err_d;
    logic             full_q, full_d;
    logic             cam_we_q, cam_we_d;
    logic             cam_match_en_q, cam_match_en_d;
    logic [KEY_W-1:0] cam_addr_q, cam_addr_d;
    logic [IDX_W-1:0] cam_din_q, cam_din_d;

    logic             accept;
    logic [IDX_W-1:0] next_idx;

    assign accept   = bus.s_valid && s_ready_q;
    assign next_idx = cnt_q + IDX_W'(1);

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        lat_d          = lat_q;
        s_ready_d      = s_ready_q;
        r_valid_d      = r_valid_q;
        r_match_d      = r_match_q;
        r_idx_d        = r_idx_q;
        r_err_d        = r_err_q;
        cam_we_d       = cam_we_q;
        cam_match_en_d = cam_match_en_q;
        cam_addr_d     = cam_addr_q;
        cam_din_d      = cam_din_q;

        case (state_q)
            ST_IDLE: begin
                s_ready_d = 1'b1;
                if (accept) begin
                    s_ready_d  = 1'b0;
                    cam_addr_d = bus.s_key;
                    lat_d      = '0;
                    if (bus.s_mode) begin
                        state_d        = ST_QUERY;
                        cam_match_en_d = 1'b1;
                    end else begin
`ifdef CAM_CTRL_DUP_CHECK_EN
                        state_d        = ST_DCHK;
                        cam_match_en_d = 1'b1;
`else
                        state_d   = ST_WRITE;
                        cam_we_d  = !full_q;
                        cam_din_d = full_q ? '0 : next_idx;
`endif
                    end
                end
            end

            // Strobe was raised on entry; the result is built on the way out.
            ST_WRITE: begin
                state_d    = ST_RESP;
                cam_we_d   = 1'b0;
                cam_addr_d = '0;
                cam_din_d  = '0;
                r_valid_d  = 1'b1;
                r_match_d  = 1'b0;
                if (!full_q) begin
                    cnt_d   = next_idx;
                    r_idx_d = next_idx;
                    r_err_d = 1'b0;
                end else begin
                    r_idx_d = '0;
                    r_err_d = 1'b1;
                end
            end

            ST_QUERY: begin
                if (lat_q == LAT_LAST) begin
                    state_d        = ST_RESP;
                    cam_match_en_d = 1'b0;
                    cam_addr_d     = '0;
                    r_valid_d      = 1'b1;
                    r_match_d      = bus.cam_match;
                    r_idx_d        = '0;
                    r_err_d        = 1'b0;
                end else begin
                    lat_d = lat_q + 2'd1;
                end
            end

`ifdef CAM_CTRL_DUP_CHECK_EN
            // Key already present: answer as a hit and skip the store entirely.
            ST_DCHK: begin
                if (lat_q == LAT_LAST) begin
                    cam_match_en_d = 1'b0;
                    if (bus.cam_match) begin
                        state_d    = ST_RESP;
                        cam_addr_d = '0;
                        r_valid_d  = 1'b1;
                        r_match_d  = 1'b1;
                        r_idx_d    = '0;
                        r_err_d    = 1'b0;
                    end else begin
                        state_d   = ST_WRITE;
                        cam_we_d  = !full_q;
                        cam_din_d = full_q ? '0 : next_idx;
                    end
                end else begin
                    lat_d = lat_q + 2'd1;
                end
            end
`endif

            ST_RESP: begin
                if (bus.r_ready) begin
                    state_d   = ST_IDLE;
                    s_ready_d = 1'b1;
                    r_valid_d = 1'b0;
                    r_match_d = 1'b0;
                    r_idx_d   = '0;
                    r_err_d   = 1'b0;
                end
            end

            default: begin
                state_d        = ST_IDLE;
                s_ready_d      = 1'b0;
                cam_we_d       = 1'b0;
                cam_match_en_d = 1'b0;
                cam_addr_d     = '0;
                cam_din_d      = '0;
            end
        endcase

        full_d = (cnt_d == CNT_MAX);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            cnt_q          <= '0;
            lat_q          <= '0;
            s_ready_q      <= 1'b0;
            r_valid_q      <= 1'b0;
            r_match_q      <= 1'b0;
            r_idx_q        <= '0;
            r_err_q        <= 1'b0;
            full_q         <= 1'b0;
            cam_we_q       <= 1'b0;
            cam_match_en_q <= 1'b0;
            cam_addr_q     <= '0;
            cam_din_q      <= '0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            lat_q          <= lat_d;
            s_ready_q      <= s_ready_d;
            r_valid_q      <= r_valid_d;
            r_match_q      <= r_match_d;
            r_idx_q        <= r_idx_d;
            r_err_q        <= r_err_d;
            full_q         <= full_d;
            cam_we_q       <= cam_we_d;
            cam_match_en_q <= cam_match_en_d;
            cam_addr_q     <= cam_addr_d;
            cam_din_q      <= cam_din_d;
        end
    end

    assign bus.s_ready      = s_ready_q;
    assign bus.r_valid      = r_valid_q;
    assign bus.r_match      = r_match_q;
    assign bus.r_idx        = r_idx_q;
    assign bus.r_err        = r_err_q;
    assign bus.full         = full_q;
    assign bus.cam_we       = cam_we_q;
    assign bus.cam_match_en = cam_match_en_q;
    assign bus.cam_addr     = cam_addr_q;
    assign bus.cam_din      = cam_din_q;
endmodule

// File: tb/tb_cam_ctrl.sv
// Bench for cam_ctrl: instance A (IDX_W=14, MATCH_LAT=1) and instance B (IDX_W=2, MATCH_LAT=3),
// each backed by a small CAM model and checked against a key-set/counter reference model.
module tb_cam_ctrl;
    localparam int unsigned CAP_A = 16383;
    localparam int unsigned CAP_B = 3;
    localparam int unsigned LAT_A = 1;
    localparam int unsigned LAT_B = 3;
`ifdef CAM_CTRL_DUP_CHECK_EN
    localparam bit DUP = 1'b1;
`else
    localparam bit DUP = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_a, rst_b;
    int unsigned checks = 0;
    int unsigned failures = 0;

    always #5 clk = ~clk;

    cam_ctrl_if #(.KEY_W(24), .IDX_W(14)) ifa ();
    cam_ctrl_if #(.KEY_W(24), .IDX_W(2))  ifb ();

    cam_ctrl #(.KEY_W(24), .IDX_W(14), .MATCH_LAT(LAT_A)) dut_a (.clk(clk), .rst(rst_a), .bus(ifa));
    cam_ctrl #(.KEY_W(24), .IDX_W(2),  .MATCH_LAT(LAT_B)) dut_b (.clk(clk), .rst(rst_b), .bus(ifb));

    // CAM environment: slot = stored index, lookup resolved half a cycle after the request
    logic [23:0] ck_a [64];
    logic [63:0] cv_a = '0;
    logic [23:0] ck_b [4];
    logic [3:0]  cv_b = '0;

    function automatic logic hit_in_a(input logic [23:0] k);
        logic h = 1'b0;
        for (int i = 0; i < 64; i++) if (cv_a[i] && ck_a[i] == k) h = 1'b1;
        return h;
    endfunction

    function automatic logic hit_in_b(input logic [23:0] k);
        logic h = 1'b0;
        for (int i = 0; i < 4; i++) if (cv_b[i] && ck_b[i] == k) h = 1'b1;
        return h;
    endfunction

    always @(negedge clk) begin
        ifa.cam_match <= ifa.cam_match_en && hit_in_a(ifa.cam_addr);
        ifb.cam_match <= ifb.cam_match_en && hit_in_b(ifb.cam_addr);
    end

    int unsigned we_a = 0, me_a = 0, both_a = 0, acc_a = 0, rsp_a = 0, hits_a = 0;
    int unsigned we_b = 0, me_b = 0, both_b = 0;
    logic [13:0] last_din_a;
    logic [23:0] last_addr_a;
    logic [1:0]  last_din_b;

    always @(posedge clk) begin
        if (ifa.cam_we) begin
            we_a <= we_a + 1;
            last_din_a <= ifa.cam_din;
            last_addr_a <= ifa.cam_addr;
            ck_a[ifa.cam_din[5:0]] <= ifa.cam_addr;
            cv_a[ifa.cam_din[5:0]] <= 1'b1;
        end
        if (ifa.cam_match_en) me_a <= me_a + 1;
        if (ifa.cam_we && ifa.cam_match_en) both_a <= both_a + 1;
        if (ifa.s_valid && ifa.s_ready) acc_a <= acc_a + 1;
        if (ifa.r_valid && ifa.r_ready) begin
            rsp_a <= rsp_a + 1;
            if (ifa.r_match) hits_a <= hits_a + 1;
        end
        if (ifb.cam_we) begin
            we_b <= we_b + 1;
            last_din_b <= ifb.cam_din;
            ck_b[ifb.cam_din] <= ifb.cam_addr;
            cv_b[ifb.cam_din] <= 1'b1;
        end
        if (ifb.cam_match_en) me_b <= me_b + 1;
        if (ifb.cam_we && ifb.cam_match_en) both_b <= both_b + 1;
    end

    // Reference model: stored key set and entry count per instance
    bit mkeys_a [logic [23:0]];
    bit mkeys_b [logic [23:0]];
    int unsigned mcnt_a = 0, mcnt_b = 0;
    logic [23:0] pool [$];

    task automatic cmd_a(input logic mode, input logic [23:0] key, output logic m,
                         output logic [13:0] idx, output logic e, output logic f,
                         output int unsigned wp, output int unsigned mp, output bit ok);
        int unsigned we0 = we_a, me0 = me_a, n = 0;
        ifa.s_mode = mode; ifa.s_key = key; ifa.s_valid = 1'b1; ifa.r_ready = 1'b1;
        while (ifa.s_ready !== 1'b1 && n < 20) begin @(negedge clk); n++; end
        @(negedge clk);
        ifa.s_valid = 1'b0;
        while (ifa.r_valid !== 1'b1 && n < 40) begin @(negedge clk); n++; end
        ok = (ifa.r_valid === 1'b1);
        m = ifa.r_match; idx = ifa.r_idx; e = ifa.r_err; f = ifa.full;
        wp = we_a - we0; mp = me_a - me0;
        @(negedge clk);
    endtask

    task automatic cmd_b(input logic mode, input logic [23:0] key, output logic m,
                         output logic [1:0] idx, output logic e, output logic f,
                         output int unsigned wp, output int unsigned mp, output bit ok);
        int unsigned we0 = we_b, me0 = me_b, n = 0;
        ifb.s_mode = mode; ifb.s_key = key; ifb.s_valid = 1'b1; ifb.r_ready = 1'b1;
        while (ifb.s_ready !== 1'b1 && n < 20) begin @(negedge clk); n++; end
        @(negedge clk);
        ifb.s_valid = 1'b0;
        while (ifb.r_valid !== 1'b1 && n < 40) begin @(negedge clk); n++; end
        ok = (ifb.r_valid === 1'b1);
        m = ifb.r_match; idx = ifb.r_idx; e = ifb.r_err; f = ifb.full;
        wp = we_b - we0; mp = me_b - me0;
        @(negedge clk);
    endtask

    task automatic write_a(input logic [23:0] key, input string tag);
        logic m, e, f, dup, xe, xf;
        logic [13:0] idx, xidx;
        int unsigned wp, mp, xwp;
        bit ok;
        dup = DUP && mkeys_a.exists(key);
        if (dup) begin xidx = '0; xe = 1'b0; xwp = 0; end
        else if (mcnt_a < CAP_A) begin
            mcnt_a++; xidx = 14'(mcnt_a); xe = 1'b0; xwp = 1; mkeys_a[key] = 1'b1;
        end else begin xidx = '0; xe = 1'b1; xwp = 0; end
        xf = (mcnt_a == CAP_A);
        cmd_a(1'b0, key, m, idx, e, f, wp, mp, ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL %s: no response within bound", tag); end
        checks++;
        if ({m, idx, e, f} !== {dup, xidx, xe, xf}) begin
            failures++;
            $display("FAIL %s: got match=%0b idx=%0d err=%0b full=%0b, want match=%0b idx=%0d err=%0b full=%0b",
                     tag, m, idx, e, f, dup, xidx, xe, xf);
        end
        checks++;
        if (wp !== xwp || mp !== (DUP ? LAT_A : 0)) begin
            failures++;
            $display("FAIL %s: got we_cycles=%0d match_en_cycles=%0d, want %0d/%0d",
                     tag, wp, mp, xwp, DUP ? LAT_A : 0);
        end
        if (xwp == 1) begin
            checks++;
            if (last_din_a !== xidx || last_addr_a !== key) begin
                failures++;
                $display("FAIL %s: got cam_din=%0d cam_addr=%h, want cam_din=%0d cam_addr=%h",
                         tag, last_din_a, last_addr_a, xidx, key);
            end
        end
    endtask

    task automatic query_a(input logic [23:0] key, input string tag);
        logic m, e, f, xm;
        logic [13:0] idx;
        int unsigned wp, mp;
        bit ok;
        xm = mkeys_a.exists(key) ? 1'b1 : 1'b0;
        cmd_a(1'b1, key, m, idx, e, f, wp, mp, ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL %s: no response within bound", tag); end
        checks++;
        if ({m, idx, e} !== {xm, 14'd0, 1'b0}) begin
            failures++;
            $display("FAIL %s: got match=%0b idx=%0d err=%0b, want match=%0b idx=0 err=0",
                     tag, m, idx, e, xm);
        end
        checks++;
        if (wp !== 0 || mp !== LAT_A) begin
            failures++;
            $display("FAIL %s: got we_cycles=%0d match_en_cycles=%0d, want 0/%0d", tag, wp, mp, LAT_A);
        end
    endtask

    task automatic write_b(input logic [23:0] key, input string tag);
        logic m, e, f, dup, xe, xf;
        logic [1:0] idx, xidx;
        int unsigned wp, mp, xwp;
        bit ok;
        dup = DUP && mkeys_b.exists(key);
        if (dup) begin xidx = '0; xe = 1'b0; xwp = 0; end
        else if (mcnt_b < CAP_B) begin
            mcnt_b++; xidx = 2'(mcnt_b); xe = 1'b0; xwp = 1; mkeys_b[key] = 1'b1;
        end else begin xidx = '0; xe = 1'b1; xwp = 0; end
        xf = (mcnt_b == CAP_B);
        cmd_b(1'b0, key, m, idx, e, f, wp, mp, ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL %s: no response within bound", tag); end
        checks++;
        if ({m, idx, e, f} !== {dup, xidx, xe, xf}) begin
            failures++;
            $display("FAIL %s: got match=%0b idx=%0d err=%0b full=%0b, want match=%0b idx=%0d err=%0b full=%0b",
                     tag, m, idx, e, f, dup, xidx, xe, xf);
        end
        checks++;
        if (wp !== xwp || (xwp == 1 && last_din_b !== xidx)) begin
            failures++;
            $display("FAIL %s: got we_cycles=%0d cam_din=%0d, want we_cycles=%0d cam_din=%0d",
                     tag, wp, last_din_b, xwp, xidx);
        end
    endtask

    task automatic test_reset;
        ifa.s_valid = 1'b0; ifa.s_mode = 1'b0; ifa.s_key = '0; ifa.r_ready = 1'b1;
        ifb.s_valid = 1'b0; ifb.s_mode = 1'b0; ifb.s_key = '0; ifb.r_ready = 1'b1;
        rst_a = 1'b1; rst_b = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({ifa.s_ready, ifa.r_valid, ifa.r_match, ifa.r_idx, ifa.r_err, ifa.full,
             ifa.cam_we, ifa.cam_match_en, ifa.cam_addr, ifa.cam_din} !== '0) begin
            failures++;
            $display("FAIL reset_a: got s_ready=%0b r_valid=%0b idx=%0d full=%0b we=%0b men=%0b addr=%h din=%0d, want all 0",
                     ifa.s_ready, ifa.r_valid, ifa.r_idx, ifa.full, ifa.cam_we, ifa.cam_match_en,
                     ifa.cam_addr, ifa.cam_din);
        end
        checks++;
        if ({ifb.s_ready, ifb.r_valid, ifb.full, ifb.cam_we, ifb.cam_match_en} !== '0) begin
            failures++;
            $display("FAIL reset_b: got s_ready=%0b r_valid=%0b full=%0b we=%0b men=%0b, want all 0",
                     ifb.s_ready, ifb.r_valid, ifb.full, ifb.cam_we, ifb.cam_match_en);
        end
        rst_a = 1'b0; rst_b = 1'b0;
        @(negedge clk);
        checks++;
        if (ifa.s_ready !== 1'b1 || ifb.s_ready !== 1'b1) begin
            failures++;
            $display("FAIL ready_after_reset: got a=%0b b=%0b, want 1/1", ifa.s_ready, ifb.s_ready);
        end
    endtask

    task automatic test_seq_writes;
        write_a(24'hFFEE11, "seq_write1");
        write_a(24'hAACB01, "seq_write2");
        write_a(24'hABCDEF, "seq_write3");
        pool.push_back(24'hFFEE11); pool.push_back(24'hAACB01); pool.push_back(24'hABCDEF);
    endtask

    task automatic test_queries;
        query_a(24'hAACB01, "query_hit");
        query_a(24'h123456, "query_miss");
    endtask

    task automatic test_duplicate_write;
        write_a(24'h112233, "dup_first");
        write_a(24'h112233, "dup_second");
        write_a(24'h445566, "after_dup");
        pool.push_back(24'h112233);
    endtask

    task automatic test_random;
        logic [23:0] k;
        for (int i = 0; i < 24; i++) begin
            if ($urandom_range(0, 1) == 1) k = pool[$urandom_range(0, pool.size() - 1)];
            else k = 24'($urandom);
            if ($urandom_range(0, 2) == 0) begin
                write_a(k, "rand_write");
                pool.push_back(k);
            end else begin
                query_a(k, "rand_query");
            end
        end
    endtask

    task automatic test_back_to_back;
        int unsigned a0, r0, h0, n = 0;
        while (ifa.s_ready !== 1'b1 && n < 20) begin @(negedge clk); n++; end
        a0 = acc_a; r0 = rsp_a; h0 = hits_a;
        ifa.s_mode = 1'b1; ifa.s_key = 24'hFFEE11; ifa.r_ready = 1'b1; ifa.s_valid = 1'b1;
        repeat (30) @(negedge clk);
        ifa.s_valid = 1'b0;
        checks++;
        if (acc_a - a0 !== 10 || rsp_a - r0 !== 10 || hits_a - h0 !== 10) begin
            failures++;
            $display("FAIL back_to_back: got accepts=%0d responses=%0d hits=%0d, want 10/10/10",
                     acc_a - a0, rsp_a - r0, hits_a - h0);
        end
    endtask

    task automatic test_backpressure;
        int unsigned n = 0;
        while (ifa.s_ready !== 1'b1 && n < 20) begin @(negedge clk); n++; end
        ifa.r_ready = 1'b0; ifa.s_mode = 1'b1; ifa.s_key = 24'hAACB01; ifa.s_valid = 1'b1;
        @(negedge clk);
        ifa.s_valid = 1'b0;
        n = 0;
        while (ifa.r_valid !== 1'b1 && n < 20) begin @(negedge clk); n++; end
        checks++;
        if (ifa.r_valid !== 1'b1) begin failures++; $display("FAIL stall_resp: got r_valid=%0b, want 1", ifa.r_valid); end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if ({ifa.r_valid, ifa.r_match, ifa.r_idx, ifa.r_err, ifa.s_ready} !== {1'b1, 1'b1, 14'd0, 1'b0, 1'b0}) begin
                failures++;
                $display("FAIL stall_hold: got r_valid=%0b match=%0b idx=%0d err=%0b s_ready=%0b, want 1/1/0/0/0",
                         ifa.r_valid, ifa.r_match, ifa.r_idx, ifa.r_err, ifa.s_ready);
            end
        end
        ifa.r_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (ifa.r_valid !== 1'b0 || ifa.s_ready !== 1'b1) begin
            failures++;
            $display("FAIL stall_release: got r_valid=%0b s_ready=%0b, want 0/1", ifa.r_valid, ifa.s_ready);
        end
    endtask

    task automatic test_full_boundary;
        write_b(24'h000001, "full_w1");
        write_b(24'h000002, "full_w2");
        write_b(24'h000003, "full_w3");
        write_b(24'h000004, "full_w4_reject");
    endtask

    task automatic test_reset_mid_query;
        int unsigned n = 0;
        while (ifb.s_ready !== 1'b1 && n < 20) begin @(negedge clk); n++; end
        ifb.s_mode = 1'b1; ifb.s_key = 24'h000001; ifb.r_ready = 1'b1; ifb.s_valid = 1'b1;
        @(negedge clk);
        ifb.s_valid = 1'b0;
        checks++;
        if (ifb.cam_match_en !== 1'b1 || ifb.cam_addr !== 24'h000001) begin
            failures++;
            $display("FAIL midq_start: got match_en=%0b addr=%h, want 1/000001", ifb.cam_match_en, ifb.cam_addr);
        end
        @(negedge clk);
        rst_b = 1'b1;
        @(negedge clk);
        checks++;
        if ({ifb.cam_match_en, ifb.r_valid, ifb.cam_addr, ifb.full} !== '0) begin
            failures++;
            $display("FAIL midq_reset: got match_en=%0b r_valid=%0b addr=%h full=%0b, want all 0",
                     ifb.cam_match_en, ifb.r_valid, ifb.cam_addr, ifb.full);
        end
        rst_b = 1'b0;
        mcnt_b = 0;
        @(negedge clk);
        write_b(24'h0000AA, "midq_next_write");
    endtask

    task automatic test_strobe_exclusive;
        checks++;
        if (both_a !== 0 || both_b !== 0) begin
            failures++;
            $display("FAIL strobe_exclusive: got overlap cycles a=%0d b=%0d, want 0/0", both_a, both_b);
        end
    endtask

    initial begin
        test_reset;
        test_seq_writes;
        test_queries;
        test_duplicate_write;
        test_random;
        test_back_to_back;
        test_backpressure;
        test_full_boundary;
        test_reset_mid_query;
        test_strobe_exclusive;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end
endmodule
